// File: rtl/out_display_ctrl.sv
// Output-register display controller: serial double-dabble binary-to-BCD plus a
// multiplexed 7-segment scanner. Optional leading-zero blanking: OUT_DISP_LZ_BLANK_EN.
module out_display_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  mclk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_data,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_busy,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_digit_en
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] last_val, last_n;
  logic [BW-1:0]    acc, acc_n, adj, shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic [BW-1:0]    bcd_n;
  logic             busy_n;

  logic [PW-1:0]     presc, presc_n;
  logic [IW-1:0]     idx, idx_n;
  logic              wrap;
  logic [DIGITS-1:0] en_n;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        seg_n;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Conversion FSM: capture on a changed value, then WIDTH add-3/shift iterations.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    last_n  = last_val;
    acc_n   = acc;
    cnt_n   = cnt;
    bcd_n   = o_bcd;
    busy_n  = o_busy;
    adj     = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted = {adj[BW-2:0], shreg[WIDTH-1]};
    case (state)
      IDLE: begin
        if (i_data != last_val) begin
          shreg_n = i_data;
          last_n  = i_data;
          acc_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        acc_n   = shifted;
        shreg_n = shreg << 1;
        cnt_n   = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          bcd_n   = shifted;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Segment data is derived from next-cycle index and BCD so o_seg follows o_bcd without lag.
  always_comb begin
    wrap    = (presc == PW'(REFRESH_DIV - 1));
    presc_n = wrap ? '0 : presc + 1'b1;
    idx_n   = idx;
    if (wrap) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    en_n  = '0;
    nib   = 4'd0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx_n) == i) begin
        en_n[i] = 1'b1;
        nib     = bcd_n[4*i +: 4];
      end
    end
`ifdef OUT_DISP_LZ_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        zero_run = zero_run && (bcd_n[4*i +: 4] == 4'd0);
        if (int'(idx_n) == i) blank = zero_run && (i != 0);
      end
    end
`else
    blank = 1'b0;
`endif
    seg_n = blank ? 7'h00 : decode(nib);
  end

  always_ff @(posedge mclk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      last_val   <= '0;
      acc        <= '0;
      cnt        <= '0;
      o_bcd      <= '0;
      o_busy     <= 1'b0;
      presc      <= '0;
      idx        <= '0;
      o_digit_en <= DIGITS'(1);
      o_seg      <= 7'h3F;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      last_val   <= last_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      o_bcd      <= bcd_n;
      o_busy     <= busy_n;
      presc      <= presc_n;
      idx        <= idx_n;
      o_digit_en <= en_n;
      o_seg      <= seg_n;
    end
  end

endmodule

// File: tb/tb_out_display_ctrl.sv
// Directed bench for out_display_ctrl (WIDTH=8, DIGITS=3, REFRESH_DIV=4).
// Inputs change and outputs are sampled on the falling edge of mclk.
module tb_out_display_ctrl;

  logic        mclk;
  logic        i_rst_n;
  logic [7:0]  i_data;
  logic [11:0] o_bcd;
  logic        o_busy;
  logic [6:0]  o_seg;
  logic [2:0]  o_digit_en;

  int checks = 0;
  int errors = 0;

  out_display_ctrl #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .mclk(mclk), .i_rst_n(i_rst_n), .i_data(i_data), .o_bcd(o_bcd),
    .o_busy(o_busy), .o_seg(o_seg), .o_digit_en(o_digit_en)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  function automatic logic [2:0] rot(input logic [2:0] e);
    return {e[1:0], e[2]};
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_data  = 8'd0;
    repeat (3) @(negedge mclk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", o_busy); end
    checks++; if (o_bcd !== 12'h000) begin errors++; $display("FAIL rst_bcd got=%h exp=000", o_bcd); end
    checks++; if (o_digit_en !== 3'b001) begin errors++; $display("FAIL rst_digit_en got=%b exp=001", o_digit_en); end
    checks++; if (o_seg !== 7'h3F) begin errors++; $display("FAIL rst_seg got=%h exp=3f", o_seg); end
    i_rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge mclk);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy k=%0d got=%0b exp=0", k, o_busy); end
      checks++; if (o_bcd !== 12'h000) begin errors++; $display("FAIL idle_bcd k=%0d got=%h exp=000", k, o_bcd); end
    end
  endtask

  task automatic test_convert_255();
    i_data = 8'd255;
    for (int k = 0; k <= 8; k++) begin
      @(negedge mclk);
      if (k < 8) begin
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL conv255_busy k=%0d got=%0b exp=1", k, o_busy); end
        checks++; if (o_bcd !== 12'h000) begin errors++; $display("FAIL conv255_hold k=%0d got=%h exp=000", k, o_bcd); end
      end else begin
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL conv255_done_busy got=%0b exp=0", o_busy); end
        checks++; if (o_bcd !== 12'h255) begin errors++; $display("FAIL conv255_bcd got=%h exp=255", o_bcd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    busy_cnt = 0;
    i_data = 8'd10;
    for (int k = 0; k <= 16; k++) begin
      @(negedge mclk);
      if (o_busy === 1'b1) busy_cnt++;
      if (k == 1) i_data = 8'd99;
      if (k == 8) begin
        checks++; if (o_bcd !== 12'h010) begin errors++; $display("FAIL b2b_first_bcd got=%h exp=010", o_bcd); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got=%0b exp=0", o_busy); end
      end
      if (k == 12) begin
        checks++; if (o_bcd !== 12'h010) begin errors++; $display("FAIL b2b_mid_bcd got=%h exp=010", o_bcd); end
      end
    end
    checks++; if (busy_cnt != 16) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=16", busy_cnt); end
    @(negedge mclk);
    checks++; if (o_bcd !== 12'h099) begin errors++; $display("FAIL b2b_second_bcd got=%h exp=099", o_bcd); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got=%0b exp=0", o_busy); end
  endtask

  // Shared by the scan and blanking scenarios: start a conversion and wait for it.
  task automatic convert_and_wait(input logic [7:0] val, output bit ok);
    i_data = val;
    ok = 1'b0;
    repeat (2) @(negedge mclk);
    for (int k = 0; k < 20; k++) begin
      if (o_busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge mclk);
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [2:0] prev, exp_en;
    logic [6:0] exp_seg;
    convert_and_wait(8'd123, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_timeout got=busy exp=idle"); end
    checks++; if (o_bcd !== 12'h123) begin errors++; $display("FAIL scan_bcd got=%h exp=123", o_bcd); end
    prev = o_digit_en;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge mclk);
      if (o_digit_en !== prev) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL scan_no_advance got=%b exp=change", o_digit_en); end
    exp_en = rot(prev);
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge mclk);
      if (j > 0 && j % 4 == 0) exp_en = rot(exp_en);
      case (exp_en)
        3'b001:  exp_seg = 7'h4F;
        3'b010:  exp_seg = 7'h5B;
        3'b100:  exp_seg = 7'h06;
        default: exp_seg = 7'h7F;
      endcase
      checks++; if (o_digit_en !== exp_en) begin errors++; $display("FAIL scan_digit_en j=%0d got=%b exp=%b", j, o_digit_en, exp_en); end
      checks++; if (o_seg !== exp_seg) begin errors++; $display("FAIL scan_seg j=%0d got=%h exp=%h", j, o_seg, exp_seg); end
    end
  endtask

  task automatic test_lz_blank();
    bit ok;
    logic [6:0] exp_seg;
    convert_and_wait(8'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lz_timeout got=busy exp=idle"); end
    checks++; if (o_bcd !== 12'h007) begin errors++; $display("FAIL lz_bcd got=%h exp=007", o_bcd); end
    for (int j = 0; j < 12; j++) begin
      @(negedge mclk);
      if (o_digit_en == 3'b001) exp_seg = 7'h07;
`ifdef OUT_DISP_LZ_BLANK_EN
      else exp_seg = 7'h00;
`else
      else exp_seg = 7'h3F;
`endif
      checks++; if (o_seg !== exp_seg) begin errors++; $display("FAIL lz_seg en=%b got=%h exp=%h", o_digit_en, o_seg, exp_seg); end
    end
  endtask

  task automatic test_reset_mid_conversion();
    i_data = 8'd200;
    for (int k = 0; k < 4; k++) begin
      @(negedge mclk);
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy k=%0d got=%0b exp=1", k, o_busy); end
    end
    i_rst_n = 1'b0;
    @(negedge mclk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", o_busy); end
    checks++; if (o_bcd !== 12'h000) begin errors++; $display("FAIL midrst_bcd got=%h exp=000", o_bcd); end
    checks++; if (o_digit_en !== 3'b001) begin errors++; $display("FAIL midrst_digit_en got=%b exp=001", o_digit_en); end
    checks++; if (o_seg !== 7'h3F) begin errors++; $display("FAIL midrst_seg got=%h exp=3f", o_seg); end
    i_rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge mclk);
      if (k < 8) begin
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL reconv_busy k=%0d got=%0b exp=1", k, o_busy); end
        checks++; if (o_bcd !== 12'h000) begin errors++; $display("FAIL reconv_hold k=%0d got=%h exp=000", k, o_bcd); end
      end else begin
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reconv_done_busy got=%0b exp=0", o_busy); end
        checks++; if (o_bcd !== 12'h200) begin errors++; $display("FAIL reconv_bcd got=%h exp=200", o_bcd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert_255();
    test_back_to_back();
    test_scan();
    test_lz_blank();
    test_reset_mid_conversion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
